// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: three-channel level fader for RGB PWM channels.
// A prescaler makes a fade tick every DIV clocks. Each tick starts a
// three-cycle sweep (CH0, CH1, CH2) in which one shared step unit moves
// one channel a single count toward its target. Snap loads all targets
// at once. Optional macro FADE_HOLD_EN adds a hold input that freezes
// the prescaler and the sweep.
module rgb_fade_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target_0,
    input  logic [WIDTH-1:0] target_1,
    input  logic [WIDTH-1:0] target_2,
    input  logic             snap,
`ifdef FADE_HOLD_EN
    input  logic             hold,
`endif
    output logic [WIDTH-1:0] level_0,
    output logic [WIDTH-1:0] level_1,
    output logic [WIDTH-1:0] level_2,
    output logic             busy
);

    localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

    typedef enum logic [1:0] {IDLE, CH0, CH1, CH2} state_t;

    state_t           state_q, state_d;
    logic [15:0]      pre_q, pre_d;
    logic [WIDTH-1:0] lvl0_q, lvl0_d;
    logic [WIDTH-1:0] lvl1_q, lvl1_d;
    logic [WIDTH-1:0] lvl2_q, lvl2_d;

    logic             hold_w;
    logic             tick;
    logic [WIDTH-1:0] cur_lvl, cur_tgt, step_lvl;

`ifdef FADE_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign tick = (pre_q == PRE_MAX);

    // Shared step unit: select the channel being visited, move it one count.
    // Stepping only when strictly below/above keeps it inside 0..2^WIDTH-1.
    always_comb begin
        cur_lvl = lvl0_q;
        cur_tgt = target_0;
        case (state_q)
            CH1:     begin cur_lvl = lvl1_q; cur_tgt = target_1; end
            CH2:     begin cur_lvl = lvl2_q; cur_tgt = target_2; end
            default: begin cur_lvl = lvl0_q; cur_tgt = target_0; end
        endcase
        if (cur_lvl < cur_tgt)
            step_lvl = cur_lvl + WIDTH'(1);
        else if (cur_lvl > cur_tgt)
            step_lvl = cur_lvl - WIDTH'(1);
        else
            step_lvl = cur_lvl;
    end

    // Next-state: snap beats everything, hold freezes, otherwise sweep.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        lvl0_d  = lvl0_q;
        lvl1_d  = lvl1_q;
        lvl2_d  = lvl2_q;
        if (snap) begin
            lvl0_d  = target_0;
            lvl1_d  = target_1;
            lvl2_d  = target_2;
            pre_d   = '0;
            state_d = IDLE;
        end else if (!hold_w) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
            case (state_q)
                IDLE: if (tick) state_d = CH0;
                CH0:  begin lvl0_d = step_lvl; state_d = CH1;  end
                CH1:  begin lvl1_d = step_lvl; state_d = CH2;  end
                CH2:  begin lvl2_d = step_lvl; state_d = IDLE; end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            lvl0_q  <= '0;
            lvl1_q  <= '0;
            lvl2_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            lvl0_q  <= lvl0_d;
            lvl1_q  <= lvl1_d;
            lvl2_q  <= lvl2_d;
        end
    end

    assign level_0 = lvl0_q;
    assign level_1 = lvl1_q;
    assign level_2 = lvl2_q;
    assign busy    = (lvl0_q != target_0) || (lvl1_q != target_1) ||
                     (lvl2_q != target_2);

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Bench for rgb_fade_ctrl (DIV=4, WIDTH=8): directed scenarios plus
// randomized targets/snap/reset against a cycle-count reference model.
module tb_rgb_fade_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] target_0, target_1, target_2;
    logic             snap;
    logic             hold;
    logic [WIDTH-1:0] level_0, level_1, level_2;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: level per channel, cycles since last tick/clear, and the
    // position within the sweep (0 = none, k = channel k-1 due this cycle).
    int m_lvl[3];
    int m_pre;
    int m_pos;

    rgb_fade_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .target_0 (target_0),
        .target_1 (target_1),
        .target_2 (target_2),
        .snap     (snap),
`ifdef FADE_HOLD_EN
        .hold     (hold),
`endif
        .level_0  (level_0),
        .level_1  (level_1),
        .level_2  (level_2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tgt(input int k);
        case (k)
            0:       return int'(target_0);
            1:       return int'(target_1);
            default: return int'(target_2);
        endcase
    endfunction

    // Advance the model across one edge using the inputs as currently driven,
    // then sample the DUT 1 time unit after the edge and compare.
    task automatic cyc();
        int nl[3];
        int np, ns;
        bit frz;
        for (int k = 0; k < 3; k++) nl[k] = m_lvl[k];
        np = m_pre;
        ns = m_pos;
`ifdef FADE_HOLD_EN
        frz = hold;
`else
        frz = 1'b0;
`endif
        if (!reset) begin
            for (int k = 0; k < 3; k++) nl[k] = 0;
            np = 0; ns = 0;
        end else if (snap) begin
            for (int k = 0; k < 3; k++) nl[k] = tgt(k);
            np = 0; ns = 0;
        end else if (!frz) begin
            if (m_pos > 0) begin
                int k = m_pos - 1;
                if (m_lvl[k] < tgt(k)) nl[k] = m_lvl[k] + 1;
                else if (m_lvl[k] > tgt(k)) nl[k] = m_lvl[k] - 1;
            end
            ns = (m_pos == 3) ? 0 : (m_pos > 0) ? m_pos + 1
                 : (m_pre == DIV - 1) ? 1 : 0;
            np = (m_pre + 1) % DIV;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) m_lvl[k] = nl[k];
        m_pre = np;
        m_pos = ns;
        chk("level_0", int'(level_0), m_lvl[0]);
        chk("level_1", int'(level_1), m_lvl[1]);
        chk("level_2", int'(level_2), m_lvl[2]);
        chk("busy", int'(busy), int'((m_lvl[0] != tgt(0)) ||
            (m_lvl[1] != tgt(1)) || (m_lvl[2] != tgt(2))));
    endtask

    task automatic set_t(input int a, input int b, input int c);
        target_0 = WIDTH'(a);
        target_1 = WIDTH'(b);
        target_2 = WIDTH'(c);
    endtask

    initial begin
        reset = 1'b0; snap = 1'b0; hold = 1'b0;
        set_t(0, 0, 0);
        for (int k = 0; k < 3; k++) m_lvl[k] = 7;  // unknown before reset
        m_pre = 0; m_pos = 0;

        // Reset state
        set_t(9, 9, 9);
        snap = 1'b1;          // reset must override snap
        repeat (3) cyc();
        chk("rst_level_0", int'(level_0), 0);
        chk("rst_busy", int'(busy), 1);
        snap = 1'b0;

        // Fade from 0 to 3/0/255: one step per tick per channel
        set_t(3, 0, 255);
        reset = 1'b1;
        repeat (DIV * 3 + 2) cyc();
        chk("fade3_level_0", int'(level_0), 3);
        repeat (DIV * 256) cyc();
        chk("fade_level_0", int'(level_0), 3);
        chk("fade_level_1", int'(level_1), 0);
        chk("fade_level_2", int'(level_2), 255);
        chk("fade_busy", int'(busy), 0);

        // Snap to 10s, then one tick moves 8/12/10 targets on t+2, t+3, t+4
        set_t(10, 10, 10);
        snap = 1'b1; cyc(); snap = 1'b0;
        set_t(8, 12, 10);
        repeat (4) cyc();
        chk("step_pre_l0", int'(level_0), 10);
        cyc();
        chk("step_l0", int'(level_0), 9);
        chk("step_l1_early", int'(level_1), 10);
        cyc();
        chk("step_l1", int'(level_1), 11);
        cyc();
        chk("step_l2", int'(level_2), 10);
        chk("step_busy", int'(busy), 1);

        // Snap coincident with a tick
        while (m_pre != DIV - 1) cyc();
        set_t(200, 100, 50);
        snap = 1'b1; cyc(); snap = 1'b0;
        chk("snap_l0", int'(level_0), 200);
        chk("snap_l2", int'(level_2), 50);
        chk("snap_busy", int'(busy), 0);

        // target_2 lowered while in CH0 takes effect in the same sweep
        set_t(200, 100, 3);
        snap = 1'b1; cyc(); snap = 1'b0;
        set_t(200, 100, 5);
        repeat (DIV) cyc();   // now in CH0
        set_t(200, 100, 0);
        repeat (3) cyc();
        chk("midseq_l2", int'(level_2), 2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                int r = $urandom_range(0, 3);
                int v = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 20);
                case ($urandom_range(0, 2))
                    0:       target_0 = WIDTH'(v);
                    1:       target_1 = WIDTH'(v);
                    default: target_2 = WIDTH'(v);
                endcase
            end
            snap  = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 99) != 0);
`ifdef FADE_HOLD_EN
            hold  = ($urandom_range(0, 5) == 0);
`endif
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_fade_ctrl.md
RGB_FADE_CTRL -- requirements
Module: rgb_fade_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bit width of targets and levels.
REQ-002 Parameter DIV, default 256: clocks per fade tick; legal range 4..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset; block held in reset while 0.
REQ-005 target_0, target_1, target_2  input  WIDTH each  requested level per channel (encoder values).
REQ-006 snap  input  1  when 1, all levels load their targets at once.
REQ-007 hold  input  1  fade freeze; port exists only when FADE_HOLD_EN is defined.
REQ-008 level_0, level_1, level_2  output  WIDTH each  registered levels driven to the PWM channels.
REQ-009 busy  output  1  1 when any level differs from its target.

Function
REQ-010 A prescaler shall count 0..DIV-1 and wrap to 0; "tick" is the cycle where prescaler == DIV-1.
REQ-011 The FSM shall have states IDLE, CH0, CH1 and CH2.
REQ-012 FSM transitions: IDLE->CH0 on tick; CH0->CH1->CH2->IDLE unconditionally, one cycle each.
REQ-013 In state CHn, level_n shall step one count toward target_n as sampled that cycle: +1 if below, -1 if above, unchanged if equal.
REQ-014 Only one channel shall update per cycle; a single shared comparator/incrementer is used.
REQ-015 Levels shall saturate by construction: never wrap past 0 or 2^WIDTH-1.
REQ-016 Latency: tick at cycle t gives the new level_0 at t+2, level_1 at t+3 and level_2 at t+4.
REQ-017 Snap=1 in any cycle shall load level_n <= target_n for all n on that edge, force FSM to IDLE and clear the prescaler.
REQ-018 Snap shall win over tick, CHn update and hold when they coincide.
REQ-019 A target change while the FSM is mid-sequence shall take effect for any channel not yet visited in that sequence.
REQ-020 Busy shall be combinational from the level registers and targets; it shall be 0 when all three are equal.
REQ-021 The prescaler shall run continuously whether or not busy.

Reset
REQ-022 On a clk edge with reset=0: level_0/1/2 = 0, prescaler = 0, FSM = IDLE.
REQ-023 Reset shall override snap, hold and any in-progress sequence; a sequence interrupted by reset shall not resume.
REQ-024 The first tick after reset release shall occur DIV-1 cycles after the first edge with reset=1.

Configuration
REQ-025 Macro FADE_HOLD_EN defined: hold port present; while hold=1 the prescaler and FSM freeze and levels are held; a sequence resumes where it stopped when hold=0.
REQ-026 Macro FADE_HOLD_EN undefined: no hold port; behaviour identical to hold tied to 0.

Verification (DIV=4, WIDTH=8)
REQ-027 Reset, then targets 3/0/255 -> level_0 reaches 3 after 3 ticks, level_1 stays 0, level_2 reaches 255 after 255 ticks; busy=0 afterwards.
REQ-028 Levels 10/10/10, targets 8/12/10 -> after 1 tick levels are 9/11/10, updating on consecutive cycles t+2, t+3, t+4.
REQ-029 Snap=1 for one cycle coincident with tick, targets 200/100/50 -> levels 200/100/50 next cycle, FSM IDLE, prescaler 0, busy 0.
REQ-030 target_2 changed from 5 to 0 while FSM in CH0, level_2=3 -> level_2 becomes 2 in that sequence.
REQ-031 Reset asserted while FSM in CH1 -> all levels 0 and FSM IDLE next edge; first post-release tick 3 cycles after release.
REQ-032 FADE_HOLD_EN defined: hold=1 during CH1 for 10 cycles -> levels unchanged; after release, CH1 then CH2 updates occur on the next two cycles.
